mem_port_arbiter: RTL and testbench

Shares the processor's single unified memory port between instruction fetch (stage 1) and data access (stage 4 lw/sw). It arbitrates, sequences the variable-latency memory handshake, and returns read data to the winning requester. It also produces per-stage stall signals that the pipeline control block ORs into its stall/nop selects.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter and pipeline control.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for an outstanding memory request; flags expiry after TIMEOUT_CYCLES busy cycles.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_r;

    // Count busy cycles; leaving BUSY restarts the count for the next access
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (!busy) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // The count starts at 0 on the first busy cycle, so TIMEOUT_CYCLES-1 marks the last one
    assign expire = busy && (count_r == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data access (data has priority).
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush_if,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t        state_r;
    arb_state_t        state_n_s;
    logic              grant_d_s;
    logic              grant_i_s;
    logic              finish_s;
    logic              expire_s;
    logic              discard_r;
    logic              discard_s;
    logic              timed_out_s;
    logic [DATA_W-1:0] rdata_s;

    logic              if_ready_r;
    logic              d_ready_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              timeout_err_r;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .busy  ((state_r == BUSY_I) || (state_r == BUSY_D)),
        .expire(expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // A real ack wins over a simultaneous expiry
    assign timed_out_s = expire_s && !mem_ack;
    assign rdata_s     = timed_out_s ? DATA_W'(TIMEOUT_DATA) : mem_rdata;
    // Flush arriving in the same cycle as the ack must still suppress the fetch result
    assign discard_s   = discard_r || ((state_r == BUSY_I) && flush_if);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and grant decode
    always_comb begin
        state_n_s = state_r;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_req) begin
                    state_n_s = BUSY_D;
                    grant_d_s = 1'b1;
                end else if (if_req && !flush_if) begin
                    state_n_s = BUSY_I;
                    grant_i_s = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || expire_s) begin
                    state_n_s = DONE;
                    finish_s  = 1'b1;
                end else begin
                    state_n_s = state_r;
                end
            end
            DONE: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Memory-side registers and requester completion
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            if_ready_r    <= 1'b0;
            d_ready_r     <= 1'b0;
            if_rdata_r    <= '0;
            d_rdata_r     <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if_ready_r <= 1'b0;
            d_ready_r  <= 1'b0;
            if (grant_d_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= d_we;
                mem_addr_r  <= d_addr;
                mem_wdata_r <= d_wdata;
            end else if (grant_i_s) begin
                mem_req_r  <= 1'b1;
                mem_we_r   <= 1'b0;
                mem_addr_r <= if_addr;
            end else if (finish_s) begin
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
                if (timed_out_s) begin
                    timeout_err_r <= 1'b1;
                end else begin
                    timeout_err_r <= timeout_err_r;
                end
                if (state_r == BUSY_D) begin
                    d_ready_r <= 1'b1;
                    if (!mem_we_r) begin
                        d_rdata_r <= rdata_s;
                    end else begin
                        d_rdata_r <= d_rdata_r;
                    end
                end else if (!discard_s) begin
                    if_ready_r <= 1'b1;
                    if_rdata_r <= rdata_s;
                end else begin
                    if_rdata_r <= if_rdata_r;
                end
            end else begin
                mem_req_r <= mem_req_r;
            end
        end
    end

    // Discard flag for a fetch redirected while its memory access is outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_r <= 1'b0;
        end else if (state_r == IDLE) begin
            discard_r <= 1'b0;
        end else if ((state_r == BUSY_I) && flush_if) begin
            discard_r <= 1'b1;
        end else begin
            discard_r <= discard_r;
        end
    end

    assign if_ready    = if_ready_r;
    assign d_ready     = d_ready_r;
    assign if_rdata    = if_rdata_r;
    assign d_rdata     = d_rdata_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign timeout_err = timeout_err_r;

    assign stall_if = if_req && !if_ready_r && !flush_if;
    assign stall_dm = d_req && !d_ready_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs change 1 time unit after posedge.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush_if;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_dm;
    logic              timeout_err;

    int compared_cnt = 0;
    int mismatch_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_dm(stall_dm), .timeout_err(timeout_err)
    );

    task automatic chk_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared_cnt++;
        if (observed !== expected) begin
            mismatch_cnt++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; flush_if = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        settle();
        chk_val("rst_mem_req", mem_req, 0);
        chk_val("rst_mem_we", mem_we, 0);
        chk_val("rst_mem_addr", mem_addr, 0);
        chk_val("rst_mem_wdata", mem_wdata, 0);
        chk_val("rst_if_ready", if_ready, 0);
        chk_val("rst_d_ready", d_ready, 0);
        chk_val("rst_if_rdata", if_rdata, 0);
        chk_val("rst_d_rdata", d_rdata, 0);
        chk_val("rst_timeout_err", timeout_err, 0);

        // Fetch only, ack one cycle after mem_req
        next_cycle(); if_req = 1'b1; if_addr = 32'h100; settle();
        chk_val("f1_stall_if_p0", stall_if, 1);
        chk_val("f1_mem_req_p0", mem_req, 0);
        next_cycle(); settle();
        chk_val("f1_mem_req_p1", mem_req, 1);
        chk_val("f1_mem_addr_p1", mem_addr, 32'h100);
        chk_val("f1_mem_we_p1", mem_we, 0);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h0050_0093; settle();
        chk_val("f1_if_ready_p2", if_ready, 0);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("f1_if_ready_p3", if_ready, 1);
        chk_val("f1_if_rdata_p3", if_rdata, 32'h0050_0093);
        chk_val("f1_mem_req_p3", mem_req, 0);
        chk_val("f1_stall_if_p3", stall_if, 0);
        next_cycle(); if_req = 1'b0; settle();
        chk_val("f1_if_ready_p4", if_ready, 0);

        // Store with ack after 4 request cycles
        next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFE_F00D; settle();
        chk_val("st_stall_dm_p0", stall_dm, 1);
        for (int p = 1; p <= 4; p++) begin
            next_cycle();
            if (p == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
            settle();
            chk_val("st_mem_req", mem_req, 1);
            chk_val("st_mem_we", mem_we, 1);
            chk_val("st_mem_addr", mem_addr, 32'h2000);
            chk_val("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            chk_val("st_d_ready_busy", d_ready, 0);
        end
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("st_d_ready_p5", d_ready, 1);
        chk_val("st_d_rdata_p5", d_rdata, 0);
        chk_val("st_mem_req_p5", mem_req, 0);
        chk_val("st_stall_dm_p5", stall_dm, 0);
        next_cycle(); d_req = 1'b0; d_we = 1'b0; settle();
        chk_val("st_d_ready_p6", d_ready, 0);

        // Simultaneous fetch and load: data first, fetch granted at p4
        next_cycle(); if_req = 1'b1; if_addr = 32'h104; d_req = 1'b1; d_addr = 32'h2004; settle();
        chk_val("pr_stall_if_p0", stall_if, 1);
        next_cycle(); settle();
        chk_val("pr_mem_addr_p1", mem_addr, 32'h2004);
        chk_val("pr_mem_we_p1", mem_we, 0);
        chk_val("pr_stall_if_p1", stall_if, 1);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h11; settle();
        chk_val("pr_stall_if_p2", stall_if, 1);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("pr_d_ready_p3", d_ready, 1);
        chk_val("pr_d_rdata_p3", d_rdata, 32'h11);
        chk_val("pr_if_ready_p3", if_ready, 0);
        chk_val("pr_stall_if_p3", stall_if, 1);
        next_cycle(); d_req = 1'b0; settle();
        chk_val("pr_mem_req_p4", mem_req, 0);
        chk_val("pr_stall_if_p4", stall_if, 1);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h00A0_0113; settle();
        chk_val("pr_mem_req_p5", mem_req, 1);
        chk_val("pr_mem_addr_p5", mem_addr, 32'h104);
        chk_val("pr_stall_if_p5", stall_if, 1);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("pr_if_ready_p6", if_ready, 1);
        chk_val("pr_if_rdata_p6", if_rdata, 32'h00A0_0113);
        next_cycle(); if_req = 1'b0; settle();

        // Flush during BUSY_I discards the fetch; redirected fetch follows
        next_cycle(); if_req = 1'b1; if_addr = 32'h180; settle();
        next_cycle(); settle();
        chk_val("fl_mem_addr_p1", mem_addr, 32'h180);
        next_cycle(); flush_if = 1'b1; settle();
        chk_val("fl_stall_if_p2", stall_if, 0);
        next_cycle(); flush_if = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; settle();
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; if_addr = 32'h200; settle();
        chk_val("fl_if_ready_p4", if_ready, 0);
        chk_val("fl_if_rdata_p4", if_rdata, 32'h00A0_0113);
        chk_val("fl_mem_req_p4", mem_req, 0);
        next_cycle(); settle();
        chk_val("fl_if_ready_p5", if_ready, 0);
        chk_val("fl_mem_req_p5", mem_req, 0);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h13; settle();
        chk_val("fl_mem_req_p6", mem_req, 1);
        chk_val("fl_mem_addr_p6", mem_addr, 32'h200);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("fl_if_ready_p7", if_ready, 1);
        chk_val("fl_if_rdata_p7", if_rdata, 32'h13);
        next_cycle(); if_req = 1'b0; settle();

        // Flush in IDLE blocks the grant; then best-case ack in the first request cycle
        next_cycle(); if_req = 1'b1; if_addr = 32'h240; flush_if = 1'b1; settle();
        next_cycle(); flush_if = 1'b0; settle();
        chk_val("fi_mem_req_p1", mem_req, 0);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h55; settle();
        chk_val("fi_mem_req_p2", mem_req, 1);
        chk_val("fi_mem_addr_p2", mem_addr, 32'h240);
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("fi_if_ready_p3", if_ready, 1);
        chk_val("fi_if_rdata_p3", if_rdata, 32'h55);
        next_cycle(); if_req = 1'b0; settle();

        // Reset during BUSY_D, then a stray ack
        next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; settle();
        next_cycle(); settle();
        chk_val("rs_mem_req_p1", mem_req, 1);
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; d_req = 1'b0; settle();
        chk_val("rs_mem_req_p3", mem_req, 0);
        chk_val("rs_d_ready_p3", d_ready, 0);
        chk_val("rs_d_rdata_p3", d_rdata, 0);
        chk_val("rs_if_rdata_p3", if_rdata, 0);
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h99; settle();
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("rs_d_ready_p5", d_ready, 0);
        chk_val("rs_if_ready_p5", if_ready, 0);
        chk_val("rs_mem_req_p5", mem_req, 0);
        chk_val("rs_d_rdata_p5", d_rdata, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: expiry after 8 busy cycles
        next_cycle(); if_req = 1'b1; if_addr = 32'h400; settle();
        for (int p = 1; p <= 8; p++) begin
            next_cycle(); settle();
            chk_val("to_mem_req_busy", mem_req, 1);
            chk_val("to_if_ready_busy", if_ready, 0);
        end
        next_cycle(); settle();
        chk_val("to_if_ready_p9", if_ready, 1);
        chk_val("to_if_rdata_p9", if_rdata, 32'hDEAD_BEEF);
        chk_val("to_err_p9", timeout_err, 1);
        chk_val("to_mem_req_p9", mem_req, 0);
        next_cycle(); if_req = 1'b0; settle();
        next_cycle(); mem_ack = 1'b1; mem_rdata = 32'h66; settle();
        next_cycle(); mem_ack = 1'b0; mem_rdata = '0; settle();
        chk_val("to_if_ready_late", if_ready, 0);
        chk_val("to_if_rdata_late", if_rdata, 32'hDEAD_BEEF);
        chk_val("to_err_sticky", timeout_err, 1);
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; settle();
        chk_val("to_err_cleared", timeout_err, 0);
`else
        chk_val("timeout_err_tied", timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
